kronos_mem_arbiter: RTL and testbench

Parametrised N-core arbiter that multiplexes every core's instruction-fetch and data ports onto one single-port synchronous RAM (1-cycle read latency) in the Kronos multi-core compliance and SoC tops. Data accesses outrank instruction fetches. Within each class, cores are served round-robin with an independent pointer per class. An optional starvation guard forces an instruction fetch through after a bounded run of data grants.

---
 rtl/kronos_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_kronos_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_mem_arbiter.sv
// N-core fetch/data arbiter onto one single-port synchronous RAM.
// Define KRONOS_ARB_STARVE_GUARD_EN to build in the fetch starvation guard.
module kronos_mem_arbiter #(
    parameter int NUM_CORES    = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int IDX_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk,
    input  logic                    rstz,
    input  logic [32*NUM_CORES-1:0] instr_addr,
    input  logic [NUM_CORES-1:0]    instr_req,
    output logic [NUM_CORES-1:0]    instr_ack,
    output logic [32*NUM_CORES-1:0] instr_data,
    input  logic [32*NUM_CORES-1:0] data_addr,
    input  logic [32*NUM_CORES-1:0] data_wr_data,
    input  logic [4*NUM_CORES-1:0]  data_mask,
    input  logic [NUM_CORES-1:0]    data_wr_en,
    input  logic [NUM_CORES-1:0]    data_req,
    output logic [NUM_CORES-1:0]    data_ack,
    output logic [32*NUM_CORES-1:0] data_rd_data,
    output logic                    mem_en,
    output logic                    mem_wr_en,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wr_data,
    output logic [3:0]              mem_mask,
    input  logic [31:0]             mem_rd_data,
    output logic                    gnt_valid,
    output logic                    gnt_is_data,
    output logic [IDX_W-1:0]        gnt_idx
);

    if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_bad_cores
        $error("NUM_CORES out of range");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT out of range");
    end

    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_CORES-1:0] req,
        input logic [IDX_W-1:0]     ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               k;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            k = (int'(ptr) + i) % NUM_CORES;
            if (!found && req[k]) begin
                pick  = IDX_W'(k);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w);
        return IDX_W'((int'(w) + 1) % NUM_CORES);
    endfunction

    logic [IDX_W-1:0] dptr;
    logic [IDX_W-1:0] iptr;
    logic [IDX_W-1:0] d_win;
    logic [IDX_W-1:0] i_win;
    logic             any_d;
    logic             any_i;
    logic             sel_d;
    logic             sel_i;
    logic             armed;
    logic             rd_v;
    logic             rd_is_data;
    logic [IDX_W-1:0] rd_idx;

    assign any_d = |data_req;
    assign any_i = |instr_req;
    assign d_win = rr_pick(data_req, dptr);
    assign i_win = rr_pick(instr_req, iptr);

`ifdef KRONOS_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign armed = (starve_cnt == 8'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            starve_cnt <= '0;
        end else if (!any_i || sel_i) begin
            starve_cnt <= '0;
        end else if (sel_d && !armed) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign armed = 1'b0;
`endif

    // No grant is issued while reset is held
    assign sel_i = rstz && any_i && (armed || !any_d);
    assign sel_d = rstz && any_d && !sel_i;

    assign gnt_valid   = sel_i || sel_d;
    assign gnt_is_data = sel_d;
    assign gnt_idx     = sel_d ? d_win : (sel_i ? i_win : '0);

    always_comb begin
        mem_en      = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_mask    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (gnt_valid && gnt_idx == IDX_W'(k)) begin
                mem_en = 1'b1;
                if (gnt_is_data) begin
                    mem_addr    = data_addr[32*k +: 32];
                    mem_wr_data = data_wr_data[32*k +: 32];
                    mem_mask    = data_mask[4*k +: 4];
                    mem_wr_en   = data_wr_en[k];
                end else begin
                    mem_addr = instr_addr[32*k +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            instr_ack  <= '0;
            data_ack   <= '0;
            dptr       <= '0;
            iptr       <= '0;
            rd_v       <= 1'b0;
            rd_is_data <= 1'b0;
            rd_idx     <= '0;
        end else begin
            instr_ack  <= '0;
            data_ack   <= '0;
            rd_v       <= 1'b0;
            rd_is_data <= sel_d;
            rd_idx     <= gnt_idx;
            if (sel_d) begin
                data_ack[d_win] <= 1'b1;
                dptr            <= rr_next(d_win);
                rd_v            <= !data_wr_en[d_win];
            end
            if (sel_i) begin
                instr_ack[i_win] <= 1'b1;
                iptr             <= rr_next(i_win);
                rd_v             <= 1'b1;
            end
        end
    end

    // RAM read data lands on the tagged lane only
    always_comb begin
        instr_data   = '0;
        data_rd_data = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (rd_v && rd_idx == IDX_W'(k)) begin
                if (rd_is_data) begin
                    data_rd_data[32*k +: 32] = mem_rd_data;
                end else begin
                    instr_data[32*k +: 32] = mem_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed self-checking bench for kronos_mem_arbiter.
// Four cores, STARVE_LIMIT=3, behavioural 1-cycle RAM.
module tb_kronos_mem_arbiter;

    localparam int N   = 4;
    localparam int LIM = 3;

    logic           clk = 1'b0;
    logic           rstz;
    logic [N*32-1:0] instr_addr;
    logic [N-1:0]    instr_req;
    logic [N-1:0]    instr_ack;
    logic [N*32-1:0] instr_data;
    logic [N*32-1:0] data_addr;
    logic [N*32-1:0] data_wr_data;
    logic [N*4-1:0]  data_mask;
    logic [N-1:0]    data_wr_en;
    logic [N-1:0]    data_req;
    logic [N-1:0]    data_ack;
    logic [N*32-1:0] data_rd_data;
    logic            mem_en;
    logic            mem_wr_en;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wr_data;
    logic [3:0]      mem_mask;
    logic [31:0]     mem_rd_data;
    logic            gnt_valid;
    logic            gnt_is_data;
    logic [1:0]      gnt_idx;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ram [0:255];

    kronos_mem_arbiter #(
        .NUM_CORES   (N),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk         (clk),
        .rstz        (rstz),
        .instr_addr  (instr_addr),
        .instr_req   (instr_req),
        .instr_ack   (instr_ack),
        .instr_data  (instr_data),
        .data_addr   (data_addr),
        .data_wr_data(data_wr_data),
        .data_mask   (data_mask),
        .data_wr_en  (data_wr_en),
        .data_req    (data_req),
        .data_ack    (data_ack),
        .data_rd_data(data_rd_data),
        .mem_en      (mem_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_mask    (mem_mask),
        .mem_rd_data (mem_rd_data),
        .gnt_valid   (gnt_valid),
        .gnt_is_data (gnt_is_data),
        .gnt_idx     (gnt_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rstz) begin
            ram[8'h40]  <= 32'h0000_0013;
            ram[8'h80]  <= 32'h1234_5678;
            ram[8'h81]  <= 32'hCAFE_F00D;
            mem_rd_data <= '0;
        end else if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b])
                        ram[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
            end else begin
                mem_rd_data <= ram[mem_addr[9:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_exp [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
                               2'd2, 2'd3, 2'd0, 2'd2};
`ifdef KRONOS_ARB_STARVE_GUARD_EN
    logic st_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    logic st_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    initial begin
        rstz         = 1'b0;
        instr_addr   = '0;
        instr_req    = '0;
        data_addr    = '0;
        data_wr_data = '0;
        data_mask    = '0;
        data_wr_en   = '0;
        data_req     = '0;
        repeat (3) step();
        check("rst_gnt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b0);
        check("rst_iack", instr_ack, 4'b0);
        check("rst_dack", data_ack, 4'b0);
        check("rst_idata", instr_data, 128'd0);
        check("rst_ddata", data_rd_data, 128'd0);
        check("rst_mem_en", mem_en, 1'b0);
        rstz = 1'b1;
        step();

        // single fetch
        instr_addr[31:0] = 32'h100;
        instr_req        = 4'b0001;
        #1;
        check("f_addr", mem_addr, 32'h100);
        check("f_ctl", {mem_en, mem_wr_en, mem_mask}, 6'b100000);
        check("f_gnt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1000);
        step();
        check("f_ack", instr_ack, 4'b0001);
        check("f_data", instr_data, {96'd0, 32'h13});
        check("f_dack", data_ack, 4'b0);
        instr_req = '0;

        // data round-robin
        data_req = 4'hF;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) data_req = 4'b1101;
            #1;
            check("rr_gnt", {gnt_valid, gnt_is_data, gnt_idx},
                  {2'b11, rr_exp[i]});
            step();
            check("rr_ack", data_ack, 4'b0001 << rr_exp[i]);
        end
        data_req = '0;

        // data write outranks fetch
        data_addr[63:32]    = 32'h208;
        data_wr_data[63:32] = 32'hDEAD_BEEF;
        data_mask[7:4]      = 4'hF;
        data_wr_en[1]       = 1'b1;
        data_req            = 4'b0010;
        instr_req           = 4'b0001;
        #1;
        check("p_gnt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1101);
        check("p_addr", mem_addr, 32'h208);
        check("p_wdata", mem_wr_data, 32'hDEAD_BEEF);
        check("p_wctl", {mem_wr_en, mem_mask}, 5'b11111);
        step();
        check("p_dack", data_ack, 4'b0010);
        check("p_dlane", data_rd_data, 128'd0);
        check("p_iack0", instr_ack, 4'b0);
        data_req   = '0;
        data_wr_en = '0;
        #1;
        check("p_ignt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1000);
        check("p_ictl", {mem_wr_en, mem_mask}, 5'b0);
        step();
        check("p_iack", instr_ack, 4'b0001);
        check("p_idata", instr_data, {96'd0, 32'h13});
        instr_req = '0;

        // starvation guard
        data_addr[63:32] = 32'h200;
        data_req         = 4'b0010;
        instr_req        = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("st_cls", gnt_is_data, st_exp[i]);
            step();
            check("st_iack", instr_ack, st_exp[i] ? 4'b0000 : 4'b0001);
        end
        data_req  = '0;
        instr_req = '0;

        // read routing
        data_addr[95:64] = 32'h200;
        data_req         = 4'b0100;
        #1;
        check("rd2_gnt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1110);
        step();
        check("rd2_ack", data_ack, 4'b0100);
        check("rd2_lane", data_rd_data, {32'd0, 32'h1234_5678, 64'd0});
        check("rd2_ilane", instr_data, 128'd0);
        data_addr[31:0] = 32'h204;
        data_req        = 4'b0001;
        #1;
        check("rd0_gnt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1100);
        step();
        check("rd0_ack", data_ack, 4'b0001);
        check("rd0_lane", data_rd_data, {96'd0, 32'hCAFE_F00D});
        data_addr[127:96] = 32'h208;
        data_req          = 4'b1000;
        #1;
        check("rd3_gnt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1111);
        step();
        check("rd3_lane", data_rd_data, {32'hDEAD_BEEF, 96'd0});
        data_req = '0;

        // reset during an in-flight read
        data_addr[63:32] = 32'h204;
        data_req         = 4'b0010;
        step();
        check("rs1_lane", data_rd_data, {64'd0, 32'hCAFE_F00D, 32'd0});
        data_req = 4'b0100;
        #1;
        check("rs_gnt", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1110);
        @(negedge clk);
        rstz = 1'b0;
        step();
        check("rs_dack", data_ack, 4'b0);
        check("rs_lane", data_rd_data, 128'd0);
        check("rs_gnt0", {gnt_valid, mem_en}, 2'b0);
        data_req = '0;
        step();
        rstz = 1'b1;
        #1;
        data_req  = 4'hF;
        instr_req = 4'hF;
        #1;
        check("rs_dptr", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1100);
        data_req = '0;
        #1;
        check("rs_iptr", {gnt_valid, gnt_is_data, gnt_idx}, 4'b1000);
        instr_req = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
